osc_freq_monitor: RTL
=====================

// Module: osc_freq_monitor
// PURPOSE
//  Fabric-side consumer of the fabric oscillator outputs: samples a monitored oscillator line
//  (e.g. RCOSC_1MHZ_O2F or XTLOSC_O2F) as asynchronous data in the CLK domain and counts its
//  rising edges over a fixed gate window. Flags out-of-range frequency, declares the clock good
//  or bad with hysteresis, latches a sticky fault. Feeds the system reset/ready sequencer.
// PARAMETERS
//  GATE_CYCLES     50000  CLK cycles per measurement window (1 ms at 50 MHz)
//  CNT_W           16     width of edge counter and COUNT output
//  EXP_MIN         950    lowest in-range edge count (inclusive)
//  EXP_MAX         1050   highest in-range edge count (inclusive)
//  SETTLE_WINDOWS  2      consecutive in-range windows needed to set CLK_OK
//  FAIL_LIMIT      3      consecutive out-of-range windows needed to clear CLK_OK
// PORTS
//  CLK        in   1      fabric clock (RCOSC_25_50MHZ_O2F); the one clock of this block
//  RESET      in   1      synchronous, active-high reset
//  ENABLE     in   1      1 = run measurements; 0 = abort and return to IDLE
//  MON_IN     in   1      monitored oscillator line, asynchronous to CLK
//  CLR_FAULT  in   1      1-cycle pulse clears FAULT
//  COUNT      out  CNT_W  edge count of last completed window
//  VALID      out  1      1-cycle pulse: COUNT/IN_RANGE updated
//  IN_RANGE   out  1      EXP_MIN <= COUNT <= EXP_MAX for last window
//  CLK_OK     out  1      monitored clock qualified good (hysteresis)
//  FAULT      out  1      sticky: set on any out-of-range window
// BEHAVIOUR
//  - Reset (sync, active-high): all outputs 0, FSM=IDLE, all counters 0, sync flops 0.
//  - MON_IN -> 2-flop synchronizer -> 1 history flop; rise = s2 & ~s3 (one CLK per edge).
//  - FSM: IDLE -> SYNC when ENABLE=1. SYNC: 3 cycles flushing synchronizer, no counting -> MEASURE.
//    MEASURE: window counter 0..GATE_CYCLES-1, edge counter += rise; after cycle GATE_CYCLES-1
//    -> EVAL. EVAL (1 cycle): latch COUNT, IN_RANGE, pulse VALID, clear both counters -> MEASURE.
//    Windows run back-to-back; exactly one dead cycle (EVAL) between windows; rise seen in
//    EVAL is discarded.
//  - Latency: VALID high the cycle after window-counter value GATE_CYCLES-1 (registered output).
//  - A rise on the final gate cycle counts toward that window.
//  - Edge counter saturates at 2^CNT_W-1 (no wrap); saturated value compares as out of range.
//  - CLK_OK: good-run counter increments per in-range window, resets on out-of-range; bad-run
//    likewise. CLK_OK set when good-run reaches SETTLE_WINDOWS; cleared when bad-run reaches
//    FAIL_LIMIT. Run counters saturate at their limit.
//  - FAULT set in EVAL if !in_range; cleared by CLR_FAULT; set and clear same cycle -> stays 1.
//  - ENABLE=0 in any state: next cycle IDLE, counters/run counters cleared, VALID=0; COUNT,
//    IN_RANGE, FAULT hold; CLK_OK cleared. Re-enable restarts via SYNC (partial window lost).
//  - RESET mid-window overrides everything, same as power-up reset.
// STRUCTURE
//  - Package osc_mon_pkg: state enum {IDLE,SYNC,MEASURE,EVAL}, SYNC_LEN=3 constant.
//  - Sub-module osc_edge_sync: 2FF synchronizer + edge detect, outputs rise pulse; rest in top.
// TESTING (sim params: GATE_CYCLES=100, EXP_MIN=9, EXP_MAX=11, SETTLE_WINDOWS=2, FAIL_LIMIT=2)
//  1 MON_IN period 10 CLK, ENABLE=1 -> each VALID shows COUNT=10, IN_RANGE=1; CLK_OK=1 at 2nd VALID.
//  2 After CLK_OK, MON_IN held 0 -> COUNT=0, IN_RANGE=0, FAULT=1 at 1st VALID; CLK_OK=0 at 2nd.
//  3 MON_IN period 2 CLK, CNT_W=4 -> COUNT=15 (saturated), IN_RANGE=0, FAULT=1.
//  4 FAULT=1, CLR_FAULT pulsed in same cycle as a bad EVAL -> FAULT stays 1; next good-window
//    CLR_FAULT -> FAULT=0.
//  5 ENABLE dropped at window cycle 50 -> no VALID, CLK_OK=0, COUNT held; re-enable -> first
//    VALID exactly 3+100+1 cycles after ENABLE sampled high.
//  6 RESET asserted mid-MEASURE for 1 cycle -> all outputs 0 next cycle, FSM IDLE.

Source files
------------

// File: rtl/osc_mon_pkg.sv
// Shared types and constants for the oscillator frequency monitor.
// State encoding and synchronizer flush length used by the top level.
package osc_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        MEASURE,
        EVAL
    } mon_state_t;

    localparam int SYNC_LEN = 3;
    localparam int RUN_W    = 8;

endpackage

// File: rtl/osc_edge_sync.sv
// Brings an asynchronous oscillator line into the CLK domain and
// emits a one-cycle pulse for every rising edge seen.
module osc_edge_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/osc_freq_monitor.sv
// Counts rising edges of a monitored oscillator over fixed gate windows,
// qualifies the clock with hysteresis and keeps a sticky fault flag.
module osc_freq_monitor
    import osc_mon_pkg::*;
#(
    parameter int GATE_CYCLES    = 50000,
    parameter int CNT_W          = 16,
    parameter int EXP_MIN        = 950,
    parameter int EXP_MAX        = 1050,
    parameter int SETTLE_WINDOWS = 2,
    parameter int FAIL_LIMIT     = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_mon_in,
    input  logic             i_clr_fault,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid,
    output logic             o_in_range,
    output logic             o_clk_ok,
    output logic             o_fault
);

    localparam int WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [WIN_W-1:0] LAST_WIN  = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(EXP_MAX);
    localparam logic [CNT_W-1:0] SAT_C     = '1;
    localparam logic [1:0]       SYNC_LAST = 2'(SYNC_LEN - 1);
    localparam logic [RUN_W-1:0] SETTLE_C  = RUN_W'(SETTLE_WINDOWS);
    localparam logic [RUN_W-1:0] FAIL_C    = RUN_W'(FAIL_LIMIT);

    mon_state_t       r_state;
    logic [1:0]       r_sync_cnt;
    logic [WIN_W-1:0] r_win;
    logic [CNT_W-1:0] r_edge;
    logic [RUN_W-1:0] r_good_run;
    logic [RUN_W-1:0] r_bad_run;

    logic             w_rise;
    logic             w_last;
    logic             w_in_range;
    logic             w_fault_set;
    logic [CNT_W-1:0] w_edge_nxt;
    logic [RUN_W-1:0] w_good_nxt;
    logic [RUN_W-1:0] w_bad_nxt;

    osc_edge_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_mon_in),
        .o_rise  (w_rise)
    );

    // A rise on the final gate cycle still belongs to this window
    assign w_edge_nxt = (r_edge == SAT_C) ? r_edge
                      : r_edge + CNT_W'(w_rise);
    assign w_last     = (r_state == MEASURE) && (r_win == LAST_WIN);
    assign w_in_range = (w_edge_nxt >= MIN_C) &&
                        (w_edge_nxt <= MAX_C) &&
                        (w_edge_nxt != SAT_C);

    assign w_good_nxt = (r_good_run >= SETTLE_C) ? r_good_run
                      : r_good_run + RUN_W'(1);
    assign w_bad_nxt  = (r_bad_run >= FAIL_C) ? r_bad_run
                      : r_bad_run + RUN_W'(1);

    // Bad result stays asserted through EVAL so a clear there cannot win
    assign w_fault_set = i_enable &&
                         ((w_last && !w_in_range) ||
                          (r_state == EVAL && !o_in_range));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_sync_cnt <= '0;
            r_win      <= '0;
            r_edge     <= '0;
            r_good_run <= '0;
            r_bad_run  <= '0;
            o_count    <= '0;
            o_valid    <= 1'b0;
            o_in_range <= 1'b0;
            o_clk_ok   <= 1'b0;
            o_fault    <= 1'b0;
        end else begin
            o_valid <= 1'b0;

            if (w_fault_set) begin
                o_fault <= 1'b1;
            end else if (i_clr_fault) begin
                o_fault <= 1'b0;
            end

            if (!i_enable) begin
                r_state    <= IDLE;
                r_sync_cnt <= '0;
                r_win      <= '0;
                r_edge     <= '0;
                r_good_run <= '0;
                r_bad_run  <= '0;
                o_clk_ok   <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_sync_cnt <= '0;
                        r_state    <= SYNC;
                    end
                    SYNC: begin
                        if (r_sync_cnt == SYNC_LAST) begin
                            r_sync_cnt <= '0;
                            r_state    <= MEASURE;
                        end else begin
                            r_sync_cnt <= r_sync_cnt + 2'd1;
                        end
                    end
                    MEASURE: begin
                        r_edge <= w_edge_nxt;
                        if (w_last) begin
                            o_count    <= w_edge_nxt;
                            o_in_range <= w_in_range;
                            o_valid    <= 1'b1;
                            r_state    <= EVAL;
                            if (w_in_range) begin
                                r_bad_run  <= '0;
                                r_good_run <= w_good_nxt;
                                if (w_good_nxt >= SETTLE_C) begin
                                    o_clk_ok <= 1'b1;
                                end
                            end else begin
                                r_good_run <= '0;
                                r_bad_run  <= w_bad_nxt;
                                if (w_bad_nxt >= FAIL_C) begin
                                    o_clk_ok <= 1'b0;
                                end
                            end
                        end else begin
                            r_win <= r_win + WIN_W'(1);
                        end
                    end
                    EVAL: begin
                        r_win   <= '0;
                        r_edge  <= '0;
                        r_state <= MEASURE;
                    end
                endcase
            end
        end
    end

endmodule
